// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sequencer
//  Description : Traffic-light phase sequencer.  Walks NS green/yellow, an
//                all-red clearance, EW green/yellow, a second clearance and an
//                optional pedestrian walk phase.  An external countdown timer
//                is loaded by a one-cycle timer_start pulse on every phase
//                entry and reports expiry with timer_done.  The emergency
//                input forces an all-red HOLD for as long as it stays high.
//
//  Ports       : clk          - single clock, rising edge
//                reset        - synchronous, active-high
//                timer_done   - one-cycle expiry pulse from the timer
//                ped_req      - pedestrian request, any length
//                emergency    - level, all-red hold while high
//                timer_start  - one-cycle pulse loading/starting the timer
//                timer_load   - timer load value, valid with timer_start
//                ns_light     - {red,yellow,green} north-south
//                ew_light     - {red,yellow,green} east-west
//                walk         - pedestrian walk indication
//                phase        - current state code
//
//  Config      : define PHASE_SEQ_PED_EN to enable the pedestrian request
//                latch and the WALK phase; without it ped_req is ignored,
//                walk stays low and CLEAR_B always returns to NS_GREEN.
//
//  Revision    : 1.0  initial release
// ============================================================================
module phase_sequencer #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] GREEN_T  = 16'd20,
   parameter logic [WIDTH-1:0] YELLOW_T = 16'd4,
   parameter logic [WIDTH-1:0] RED_T    = 16'd2,
   parameter logic [WIDTH-1:0] WALK_T   = 16'd10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             timer_done,
   input  logic             ped_req,
   input  logic             emergency,
   output logic             timer_start,
   output logic [WIDTH-1:0] timer_load,
   output logic [2:0]       ns_light,
   output logic [2:0]       ew_light,
   output logic             walk,
   output logic [2:0]       phase
);

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      CLEAR_A   = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      CLEAR_B   = 3'd5,
      WALK      = 3'd6,
      HOLD      = 3'd7
   } state_t;

   localparam logic [2:0] c_RED    = 3'b100;
   localparam logic [2:0] c_YELLOW = 3'b010;
   localparam logic [2:0] c_GREEN  = 3'b001;

   state_t           r_state;
   state_t           w_next;
   logic             r_fresh;        // first cycle after reset: CLEAR_B not yet entered
   logic             r_timer_start;
   logic [WIDTH-1:0] r_timer_load;
   logic [2:0]       r_ns;
   logic [2:0]       r_ew;
   logic             r_walk;

   logic             w_done_ok;
   logic             w_ped_pending;
   logic             w_start_nxt;
   logic [WIDTH-1:0] w_state_load;
   logic [WIDTH-1:0] w_load_nxt;
   logic [2:0]       w_ns_nxt;
   logic [2:0]       w_ew_nxt;
   logic             w_walk_nxt;

   // A done pulse seen while the timer is being (re)loaded, or in the cycle
   // right after reset, belongs to an abandoned count and must not advance us.
   assign w_done_ok = timer_done && !r_timer_start && !r_fresh;

`ifdef PHASE_SEQ_PED_EN
   logic r_ped_pending;

   // A request in the same cycle as WALK entry is kept, so it earns the next
   // WALK rather than being swallowed by the one just starting.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ped_pending <= 1'b0;
      end else if (ped_req) begin
         r_ped_pending <= 1'b1;
      end else if ((w_next == WALK) && (r_state != WALK)) begin
         r_ped_pending <= 1'b0;
      end
   end

   assign w_ped_pending = r_ped_pending;
`else
   logic w_unused_ped_req;

   assign w_unused_ped_req = ped_req;
   assign w_ped_pending    = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      if (emergency) begin
         w_next = HOLD;
      end else begin
         case (r_state)
            NS_GREEN:  if (w_done_ok) w_next = NS_YELLOW;
            NS_YELLOW: if (w_done_ok) w_next = CLEAR_A;
            CLEAR_A:   if (w_done_ok) w_next = EW_GREEN;
            EW_GREEN:  if (w_done_ok) w_next = EW_YELLOW;
            EW_YELLOW: if (w_done_ok) w_next = CLEAR_B;
            CLEAR_B:   if (w_done_ok) w_next = w_ped_pending ? WALK : NS_GREEN;
            WALK:      if (w_done_ok) w_next = NS_GREEN;
            HOLD:      w_next = CLEAR_B;
            default:   w_next = CLEAR_B;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Output decode from the next state so every output is registered and
   // lines up with the state it describes.
   // ------------------------------------------------------------------------
   always_comb begin
      w_ns_nxt     = c_RED;
      w_ew_nxt     = c_RED;
      w_walk_nxt   = 1'b0;
      w_state_load = RED_T;
      case (w_next)
         NS_GREEN: begin
            w_ns_nxt     = c_GREEN;
            w_state_load = GREEN_T;
         end
         NS_YELLOW: begin
            w_ns_nxt     = c_YELLOW;
            w_state_load = YELLOW_T;
         end
         EW_GREEN: begin
            w_ew_nxt     = c_GREEN;
            w_state_load = GREEN_T;
         end
         EW_YELLOW: begin
            w_ew_nxt     = c_YELLOW;
            w_state_load = YELLOW_T;
         end
         WALK: begin
            w_walk_nxt   = 1'b1;
            w_state_load = WALK_T;
         end
         default: begin
            w_state_load = RED_T;
         end
      endcase

      // The reset state is CLEAR_B without a timer load, so the first active
      // cycle counts as an entry even though the state code is unchanged.
      w_start_nxt = (w_next != HOLD) && ((w_next != r_state) || r_fresh);
      w_load_nxt  = w_start_nxt ? w_state_load : r_timer_load;
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= CLEAR_B;
         r_fresh       <= 1'b1;
         r_timer_start <= 1'b0;
         r_timer_load  <= '0;
         r_ns          <= c_RED;
         r_ew          <= c_RED;
         r_walk        <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_fresh       <= 1'b0;
         r_timer_start <= w_start_nxt;
         r_timer_load  <= w_load_nxt;
         r_ns          <= w_ns_nxt;
         r_ew          <= w_ew_nxt;
         r_walk        <= w_walk_nxt;
      end
   end

   assign timer_start = r_timer_start;
   assign timer_load  = r_timer_load;
   assign ns_light    = r_ns;
   assign ew_light    = r_ew;
   assign walk        = r_walk;
   assign phase       = r_state;

endmodule
`default_nettype wire
